// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and header field sizes.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_PC  = 3'd0,
        ST_HDR_CNT = 3'd1,
        ST_DATA    = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam int PC_BYTES   = 8;
    localparam int CNT_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte stream in, instruction-memory write port out; the loader sits on the slave side.
interface imem_boot_loader_if;
    // Stream: a byte moves on a rising edge where in_valid and in_ready are both high;
    // in_data must hold steady while in_valid is high and in_ready is low.
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Little-endian N-byte shift register: each accepted byte enters at the top, so after
// N shifts the first byte sits in the least-significant lane.
module imem_boot_loader_byte_word_assembler #(
    parameter int N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   resetl,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [8*N_BYTES-1:0]   value,
    output logic [8*N_BYTES-1:0]   value_next,
    output logic                   word_done
);
    localparam int LW = $clog2(N_BYTES);

    logic [LW-1:0] lane;

    assign value_next = {byte_in, value[8*N_BYTES-1:8]};
    assign word_done  = shift_en && (lane == LW'(N_BYTES - 1));

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            value <= '0;
            lane  <= '0;
        end else if (clr) begin
            lane <= '0;
        end else if (shift_en) begin
            value <= value_next;
            lane  <= word_done ? '0 : lane + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte-serial program image into instruction memory, then releases the core's
// reset with the image's entry PC.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 32
) (
    input  logic                   CLK,
    input  logic                   resetl,
    imem_boot_loader_if.slave      bus,
    input  logic                   reload,
    output logic                   core_resetl,
    output logic [63:0]            core_startpc,
    output logic                   done,
    output logic                   error,
    output state_t                 state_dbg
);
    state_t               state;
    logic                 accept;
    logic [CNT_W-1:0]     idx;
    logic                 we_q;
    logic [63:0]          addr_q;
    logic [31:0]          wdata_q;

    logic                 pc_done, cnt_done, word_done;
    logic [63:0]          unused_pc_next;
    logic [CNT_W-1:0]     cnt_val, cnt_next;
    logic [31:0]          unused_word_val, word_next;

    assign bus.in_ready  = resetl &&
                           (state == ST_HDR_PC || state == ST_HDR_CNT || state == ST_DATA);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign state_dbg      = state;

    // The PC field register doubles as core_startpc; it only shifts while the core is held.
    imem_boot_loader_byte_word_assembler #(.N_BYTES(PC_BYTES)) u_pc (
        .clk(CLK), .resetl(resetl), .clr(state != ST_HDR_PC),
        .shift_en(accept && state == ST_HDR_PC), .byte_in(bus.in_data),
        .value(core_startpc), .value_next(unused_pc_next), .word_done(pc_done)
    );

    imem_boot_loader_byte_word_assembler #(.N_BYTES(CNT_BYTES)) u_cnt (
        .clk(CLK), .resetl(resetl), .clr(state != ST_HDR_CNT),
        .shift_en(accept && state == ST_HDR_CNT), .byte_in(bus.in_data),
        .value(cnt_val), .value_next(cnt_next), .word_done(cnt_done)
    );

    imem_boot_loader_byte_word_assembler #(.N_BYTES(WORD_BYTES)) u_word (
        .clk(CLK), .resetl(resetl), .clr(state != ST_DATA),
        .shift_en(accept && state == ST_DATA), .byte_in(bus.in_data),
        .value(unused_word_val), .value_next(word_next), .word_done(word_done)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= ST_HDR_PC;
            idx         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_resetl <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                ST_HDR_PC: begin
                    if (pc_done) state <= ST_HDR_CNT;
                end
                ST_HDR_CNT: begin
                    if (cnt_done) begin
                        idx <= '0;
                        if (cnt_next > CNT_W'(MAX_WORDS)) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else if (cnt_next == '0) begin
                            state       <= ST_RUN;
                            core_resetl <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_done) begin
                        we_q    <= 1'b1;
                        wdata_q <= word_next;
                        addr_q  <= core_startpc + {{(62 - CNT_W){1'b0}}, idx, 2'b00};
                        idx     <= idx + 1'b1;
                        // Release the core alongside the final write strobe.
                        if (idx + 1'b1 == cnt_val) begin
                            state       <= ST_RUN;
                            core_resetl <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state       <= ST_HDR_PC;
                        core_resetl <= 1'b0;
                        done        <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (reload) begin
                        state <= ST_HDR_PC;
                        error <= 1'b0;
                    end
                end
                default: state <= ST_HDR_PC;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: scoreboard of expected memory writes plus
// direct checks on handshake, reset, and core-release behaviour.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int MAX_WORDS = 256;

    logic        CLK;
    logic        resetl;
    logic        reload;
    logic        core_resetl;
    logic [63:0] core_startpc;
    logic        done;
    logic        error;
    state_t      state_dbg;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(32)) dut (
        .CLK(CLK), .resetl(resetl), .bus(bus), .reload(reload),
        .core_resetl(core_resetl), .core_startpc(core_startpc),
        .done(done), .error(error), .state_dbg(state_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    logic [95:0] exp_q[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe must match the head of the expected queue
    always @(negedge CLK) begin
        if (resetl && bus.imem_we) begin
            if (exp_q.size() == 0)
                chk("spurious_we", bus.imem_we, 1'b0);
            else
                chk("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g = 0;
        int n = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && g < 8) begin
                bus.in_valid = 1'b0;
                @(negedge CLK);
                g++;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1'b1);
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [63:0] pc, input logic [31:0] n, input bit gaps);
        for (int i = 0; i < 8; i++) send_byte(pc[8*i +: 8], gaps);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps);
    endtask

    task automatic send_image(input logic [63:0] pc, input logic [31:0] n,
                              input logic [31:0] w0, input logic [31:0] w1, input bit gaps);
        logic [31:0] w;
        send_header(pc, n, gaps);
        if (n <= MAX_WORDS) begin
            for (int k = 0; k < int'(n); k++) begin
                w = (k == 0) ? w0 : (k == 1) ? w1 : $urandom();
                exp_q.push_back({pc + 64'(k) * 64'd4, w});
                for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gaps);
            end
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [63:0] pc);
        chk({tag, "_core_resetl"}, core_resetl, 1'b1);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_startpc"}, core_startpc, pc);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        @(negedge CLK);
        chk({tag, "_we_low"}, bus.imem_we, 1'b0);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_we"}, bus.imem_we, 1'b0);
        chk({tag, "_addr"}, bus.imem_addr, 64'h0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'h0);
        chk({tag, "_core_resetl"}, core_resetl, 1'b0);
        chk({tag, "_startpc"}, core_startpc, 64'h0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_state"}, state_dbg, ST_HDR_PC);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        resetl       = 1'b0;
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        resetl = 1'b1;
        @(negedge CLK);
        chk("post_reset_in_ready", bus.in_ready, 1'b1);

        // 1: two-word image at 0x100; final write and core release share a cycle
        send_image(64'h100, 32'd2, 32'hF84003E9, 32'h8B0A0128, 1'b0);
        chk("t1_final_we", bus.imem_we, 1'b1);
        check_run("t1", 64'h100);
        pulse_reload();
        chk("t1_reload_core_resetl", core_resetl, 1'b0);
        chk("t1_reload_in_ready", bus.in_ready, 1'b1);

        // 2: empty image goes straight to RUN
        send_image(64'h300, 32'd0, 32'h0, 32'h0, 1'b0);
        chk("t2_state", state_dbg, ST_RUN);
        check_run("t2", 64'h300);
        pulse_reload();

        // 3: oversize count is an error with no writes
        send_image(64'h400, 32'(MAX_WORDS + 1), 32'h0, 32'h0, 1'b0);
        chk("t3_error", error, 1'b1);
        chk("t3_in_ready", bus.in_ready, 1'b0);
        chk("t3_core_resetl", core_resetl, 1'b0);
        repeat (3) @(negedge CLK);
        chk("t3_still_held", core_resetl, 1'b0);
        pulse_reload();
        chk("t3_reload_error", error, 1'b0);
        chk("t3_reload_in_ready", bus.in_ready, 1'b1);

        // 4: same image as case 1 with random valid gaps
        send_image(64'h100, 32'd2, 32'hF84003E9, 32'h8B0A0128, 1'b1);
        check_run("t4", 64'h100);
        pulse_reload();

        // 5: reset mid-image, after two bytes of the second word
        send_header(64'h500, 32'd2, 1'b0);
        w = 32'hA5A5_1234;
        exp_q.push_back({64'h500, w});
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        chk("t5_pending", exp_q.size(), 0);
        #2 resetl = 1'b0;
        #1 check_reset_values("t5_reset");
        @(negedge CLK);
        resetl = 1'b1;
        @(negedge CLK);
        send_image(64'h1000, 32'd3, $urandom(), $urandom(), 1'b0);
        check_run("t5_fresh", 64'h1000);
        pulse_reload();

        // address wrap modulo 2^64 is silent
        send_image(64'hFFFF_FFFF_FFFF_FFFC, 32'd2, 32'h0BAD_F00D, 32'h1234_5678, 1'b0);
        check_run("wrap", 64'hFFFF_FFFF_FFFF_FFFC);
        pulse_reload();

        // largest legal image
        send_image(64'h8000, 32'(MAX_WORDS), $urandom(), $urandom(), 1'b0);
        chk("max_error", error, 1'b0);
        check_run("max", 64'h8000);

        // 6: reload from RUN, second image at 0x200
        chk("t6_pre_core_resetl", core_resetl, 1'b1);
        pulse_reload();
        chk("t6_core_resetl", core_resetl, 1'b0);
        chk("t6_in_ready", bus.in_ready, 1'b1);
        chk("t6_done", done, 1'b0);
        send_image(64'h200, 32'd4, $urandom(), $urandom(), 1'b1);
        check_run("t6", 64'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
